fp_add_pipe: RTL

- Parametrised, pipelined IEEE-754-style floating-point adder/subtractor for the CNN datapath (partial-sum accumulation, bias add).
- Generalises the fp16 combinational adder: configurable exponent/mantissa widths, add/sub mode, round-to-nearest-even, 3-stage pipeline with valid/ready backpressure, per-result exception flags.
- Sits between the MAC array output and the accumulator buffer.

---
 rtl/fp_add_pipe.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/fp_add_pipe.sv
// fp_add_pipe: 3-stage pipelined floating-point adder/subtractor with RNE rounding,
// flush-to-zero denormals, exception flags and valid/ready backpressure.
module fp_add_pipe #(
    parameter  int unsigned EXP_W = 5,
    parameter  int unsigned MAN_W = 10,
    localparam int unsigned W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic [3:0]   out_flags
);
    localparam int unsigned MW     = MAN_W + 4;      // hidden, man, G, R, S
    localparam int unsigned SW     = MAN_W + 5;      // plus carry
    localparam int unsigned XW     = EXP_W + 2;      // signed exponent path
    localparam int unsigned SH_MAX = MAN_W + 3;
    localparam int unsigned AW     = 2 * MAN_W + 4;  // alignment window
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [EXP_W-1:0] EXP_ZERO = '0;
    localparam logic [MAN_W-1:0] MAN_ONES = '1;
    localparam logic [MAN_W-1:0] MAN_ZERO = '0;
    localparam logic [W-2:0]     MAG_ZERO = '0;
    localparam logic signed [XW-1:0] EXP_TOP = XW'(EXP_ONES);

    logic advance;
    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    // Stage 1: unpack, classify, order by magnitude, align the smaller operand
    logic             sa, sb, a_zero, b_zero, a_nan, b_nan, a_inf, b_inf, flush_in, a_ge, s_big;
    logic [EXP_W-1:0] ea, eb, e_big, e_sml, diff;
    logic [MAN_W-1:0] ma, mb, m_big, m_sml;
    logic [31:0]      sh;
    logic [AW-1:0]    wide;
    logic             spec_n;
    logic [W-1:0]     spec_val_n;
    logic [3:0]       spec_flags_n;

    always_comb begin
        sa = in_a[W-1];
        ea = in_a[W-2:MAN_W];
        ma = in_a[MAN_W-1:0];
        sb = in_b[W-1] ^ in_sub;
        eb = in_b[W-2:MAN_W];
        mb = in_b[MAN_W-1:0];
        a_zero   = (ea == EXP_ZERO);
        b_zero   = (eb == EXP_ZERO);
        a_nan    = (ea == EXP_ONES) && (ma != MAN_ZERO);
        b_nan    = (eb == EXP_ONES) && (mb != MAN_ZERO);
        a_inf    = (ea == EXP_ONES) && (ma == MAN_ZERO);
        b_inf    = (eb == EXP_ONES) && (mb == MAN_ZERO);
        flush_in = (a_zero && (ma != MAN_ZERO)) || (b_zero && (mb != MAN_ZERO));
        a_ge  = {ea, ma} >= {eb, mb};
        s_big = a_ge ? sa : sb;
        e_big = a_ge ? ea : eb;
        m_big = a_ge ? ma : mb;
        e_sml = a_ge ? eb : ea;
        m_sml = a_ge ? mb : ma;
        diff  = e_big - e_sml;
        sh    = (32'(diff) > SH_MAX) ? SH_MAX : 32'(diff);
        wide  = {1'b1, m_sml, {(MAN_W + 3){1'b0}}} >> sh;

        spec_n       = 1'b0;
        spec_val_n   = '0;
        spec_flags_n = '0;
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            spec_n       = 1'b1;
            spec_val_n   = {1'b0, EXP_ONES, MAN_ONES};
            spec_flags_n = 4'b1000;
        end else if (a_inf || b_inf) begin
            spec_n       = 1'b1;
            spec_val_n   = {a_inf ? sa : sb, EXP_ONES, MAN_ZERO};
            spec_flags_n = {2'b01, flush_in, 1'b0};
        end else if (a_zero && b_zero) begin
            spec_n       = 1'b1;
            spec_val_n   = {sa & sb, MAG_ZERO};
            spec_flags_n = {2'b00, flush_in, 1'b0};
        end else if (a_zero) begin
            spec_n       = 1'b1;
            spec_val_n   = {sb, eb, mb};
            spec_flags_n = {2'b00, flush_in, 1'b0};
        end else if (b_zero) begin
            spec_n       = 1'b1;
            spec_val_n   = {sa, ea, ma};
            spec_flags_n = {2'b00, flush_in, 1'b0};
        end
    end

    logic             v1, sp1, sg1, sub1;
    logic [W-1:0]     spv1;
    logic [3:0]       spf1;
    logic [EXP_W-1:0] ex1;
    logic [MW-1:0]    big1, sml1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            sp1  <= 1'b0;
            sg1  <= 1'b0;
            sub1 <= 1'b0;
            spv1 <= '0;
            spf1 <= '0;
            ex1  <= '0;
            big1 <= '0;
            sml1 <= '0;
        end else if (advance) begin
            v1 <= in_valid;
            if (in_valid) begin
                sp1  <= spec_n;
                spv1 <= spec_val_n;
                spf1 <= spec_flags_n;
                sg1  <= s_big;
                sub1 <= sa ^ sb;
                ex1  <= e_big;
                big1 <= {1'b1, m_big, 3'b000};
                sml1 <= {wide[AW-1 -: MAN_W + 3], |wide[MAN_W:0]};
            end
        end
    end

    // Stage 2: magnitude add/subtract (big >= small, so never negative)
    logic [SW-1:0] sum_n;
    always_comb begin
        sum_n = sub1 ? ({1'b0, big1} - {1'b0, sml1}) : ({1'b0, big1} + {1'b0, sml1});
    end

    logic             v2, sp2, sg2, zero2;
    logic [W-1:0]     spv2;
    logic [3:0]       spf2;
    logic [EXP_W-1:0] ex2;
    logic [SW-1:0]    sum2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2    <= 1'b0;
            sp2   <= 1'b0;
            sg2   <= 1'b0;
            zero2 <= 1'b0;
            spv2  <= '0;
            spf2  <= '0;
            ex2   <= '0;
            sum2  <= '0;
        end else if (advance) begin
            v2 <= v1;
            if (v1) begin
                sp2   <= sp1;
                spv2  <= spv1;
                spf2  <= spf1;
                sg2   <= sg1;
                ex2   <= ex1;
                sum2  <= sum_n;
                zero2 <= (sum_n == '0);
            end
        end
    end

    // Stage 3: normalise, round to nearest even, select exceptions, pack
    int unsigned             lz;
    logic [MW-1:0]           norm;
    logic signed [XW-1:0]    exp_n, exp_r;
    logic [MAN_W:0]          mant;
    logic [MAN_W+1:0]        mant_r;
    logic [MAN_W-1:0]        man_f;
    logic                    g, r, st, rnd_up, inexact;
    logic [W-1:0]            res_n;
    logic [3:0]              flags_n;

    always_comb begin
        lz = MW;
        for (int unsigned i = 0; i < MW; i++) begin
            if (sum2[i]) lz = MW - 1 - i;
        end
        if (sum2[SW-1]) begin
            norm  = {sum2[SW-1:2], sum2[1] | sum2[0]};
            exp_n = XW'(ex2) + XW'(1);
        end else begin
            norm  = sum2[MW-1:0] << lz;
            exp_n = XW'(ex2) - XW'(lz);
        end
        mant    = norm[MW-1:3];
        g       = norm[2];
        r       = norm[1];
        st      = norm[0];
        rnd_up  = g & (r | st | mant[0]);
        mant_r  = {1'b0, mant} + (MAN_W + 2)'(rnd_up);
        exp_r   = mant_r[MAN_W+1] ? exp_n + XW'(1) : exp_n;
        man_f   = mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
        inexact = g | r | st;

        res_n   = '0;
        flags_n = '0;
        if (sp2) begin
            res_n   = spv2;
            flags_n = spf2;
        end else if (zero2) begin
            res_n   = '0;
            flags_n = '0;
        end else if (exp_r >= EXP_TOP) begin
            res_n   = {sg2, EXP_ONES, MAN_ZERO};
            flags_n = {2'b01, 1'b0, inexact};
        end else if (exp_r[XW-1] || (exp_r == '0)) begin
            res_n   = '0;
            flags_n = {2'b00, 1'b1, inexact};
        end else begin
            res_n   = {sg2, exp_r[EXP_W-1:0], man_f};
            flags_n = {3'b000, inexact};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_flags <= '0;
        end else if (advance) begin
            out_valid <= v2;
            if (v2) begin
                out_sum   <= res_n;
                out_flags <= flags_n;
            end
        end
    end
endmodule
